// File: rtl/bk_sd_if.sv
// Sector handshake bundle between the backup-RAM controller and the HPS SD block.
// The master side is the controller; the slave side is the HPS/bench.
interface bk_sd_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        sd_buff_wr;
  logic [6:0]  bram_sector;
  logic        bram_we;

  modport master (
    output sd_lba, sd_rd, sd_wr, bram_sector, bram_we,
    input  sd_ack, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, bram_sector, bram_we,
    output sd_ack, sd_buff_wr
  );
endinterface

// File: rtl/bk_sd_ctrl.sv
// Backup-RAM load/save sequencer: streams SECTORS sectors to/from the save image.
// Define BK_AUTOSAVE_EN to let a pending change trigger a save when the OSD opens.
module bk_sd_ctrl #(
  parameter int SECTORS = 128
) (
  input  logic      clk_sys,
  input  logic      reset,
  input  logic      cart_download,
  input  logic      img_mounted,
  input  logic      img_readonly,
  input  logic      img_size_nz,
  input  logic      load_req,
  input  logic      save_req,
  input  logic      autosave_en,
  input  logic      osd_status,
  input  logic      bram_change,
  bk_sd_if.master   sd,
  output logic      bk_ena,
  output logic      bk_loading,
  output logic      bk_busy,
  output logic      sav_pending
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [6:0] LAST_SECTOR = 7'(SECTORS - 1);

  state_t     state_q, state_d;
  logic [6:0] lba_q, lba_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       loading_q, loading_d;
  logic       ena_q, ena_d;
  logic       pend_q, pend_d;

  // armed_q masks edge detection on the first cycle out of reset
  logic armed_q;
  logic load_req_q, save_trig_q, cart_dl_q, sd_ack_q;
  logic save_trig;

`ifdef BK_AUTOSAVE_EN
  assign save_trig = save_req | (pend_q & osd_status & autosave_en);
`else
  logic unused_autosave;
  assign unused_autosave = autosave_en;
  assign save_trig       = save_req;
`endif

  logic load_rise, save_rise, dl_rise, dl_fall, ack_rise, ack_fall;
  assign load_rise = armed_q & load_req      & ~load_req_q;
  assign save_rise = armed_q & save_trig     & ~save_trig_q;
  assign dl_rise   = armed_q & cart_download & ~cart_dl_q;
  assign dl_fall   = armed_q & ~cart_download & cart_dl_q;
  assign ack_rise  = armed_q & sd.sd_ack     & ~sd_ack_q;
  assign ack_fall  = armed_q & ~sd.sd_ack    & sd_ack_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      lba_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      loading_q   <= 1'b0;
      ena_q       <= 1'b0;
      pend_q      <= 1'b0;
      armed_q     <= 1'b0;
      load_req_q  <= 1'b0;
      save_trig_q <= 1'b0;
      cart_dl_q   <= 1'b0;
      sd_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lba_q       <= lba_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      loading_q   <= loading_d;
      ena_q       <= ena_d;
      pend_q      <= pend_d;
      armed_q     <= 1'b1;
      load_req_q  <= load_req;
      save_trig_q <= save_trig;
      cart_dl_q   <= cart_download;
      sd_ack_q    <= sd.sd_ack;
    end
  end

  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    loading_d = loading_q;
    ena_d     = ena_q;
    pend_d    = pend_q;

    if (dl_rise) ena_d = 1'b0;
    if (cart_download & img_mounted & ~img_readonly) ena_d = 1'b1;

    if (bram_change & ~osd_status) pend_d = 1'b1;
    else if (state_q == XFER)      pend_d = 1'b0;

    if (ack_rise) begin
      rd_d = 1'b0;
      wr_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // Requests only start from IDLE; anything seen during XFER is dropped
        if ((dl_fall & img_size_nz & ena_q) | (load_rise & ena_q)) begin
          state_d   = XFER;
          lba_d     = '0;
          loading_d = 1'b1;
          rd_d      = 1'b1;
          wr_d      = 1'b0;
        end else if (save_rise & ena_q) begin
          state_d   = XFER;
          lba_d     = '0;
          loading_d = 1'b0;
          rd_d      = 1'b0;
          wr_d      = 1'b1;
        end
      end
      XFER: begin
        if (ack_fall) begin
          if (lba_q == LAST_SECTOR) begin
            loading_d = 1'b0;
            state_d   = IDLE;
          end else begin
            lba_d = lba_q + 7'd1;
            rd_d  = loading_q;
            wr_d  = ~loading_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sd.sd_lba      = {25'd0, lba_q};
  assign sd.sd_rd       = rd_q;
  assign sd.sd_wr       = wr_q;
  assign sd.bram_sector = lba_q;
  assign sd.bram_we     = sd.sd_buff_wr & sd.sd_ack & loading_q;

  assign bk_ena      = ena_q;
  assign bk_loading  = loading_q;
  assign bk_busy     = (state_q == XFER);
  assign sav_pending = pend_q;

endmodule

// File: tb/tb_bk_sd_ctrl.sv
// Directed bench for bk_sd_ctrl: load/save sequencing, gating, reset abort, autosave.
module tb_bk_sd_ctrl;
  logic clk_sys = 1'b0;
  logic reset, cart_download, img_mounted, img_readonly, img_size_nz;
  logic load_req, save_req, autosave_en, osd_status, bram_change;
  logic bk_ena, bk_loading, bk_busy, sav_pending;
  int   total = 0;
  int   bad   = 0;

  bk_sd_if sd ();

  bk_sd_ctrl #(.SECTORS(128)) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .cart_download (cart_download),
    .img_mounted   (img_mounted),
    .img_readonly  (img_readonly),
    .img_size_nz   (img_size_nz),
    .load_req      (load_req),
    .save_req      (save_req),
    .autosave_en   (autosave_en),
    .osd_status    (osd_status),
    .bram_change   (bram_change),
    .sd            (sd.slave),
    .bk_ena        (bk_ena),
    .bk_loading    (bk_loading),
    .bk_busy       (bk_busy),
    .sav_pending   (sav_pending)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  // One sector handshake: wait for the request, ack with a buffer strobe, release ack.
  task automatic do_sector(input int lba, input logic is_load);
    int n = 0;
    while (!(sd.sd_rd || sd.sd_wr) && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    chk("req_seen", 32'(n < 20), 32'd1);
    chk("lba", sd.sd_lba, 32'(lba));
    chk("bram_sector", 32'(sd.bram_sector), 32'(lba & 127));
    chk("rd", 32'(sd.sd_rd), 32'(is_load));
    chk("wr", 32'(sd.sd_wr), 32'(!is_load));
    sd.sd_ack = 1'b1;
    sd.sd_buff_wr = 1'b1;
    @(negedge clk_sys);
    chk("bram_we", 32'(sd.bram_we), 32'(is_load));
    chk("req_cleared", 32'(sd.sd_rd | sd.sd_wr), 32'd0);
    sd.sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    chk("busy_in_ack", 32'(bk_busy), 32'd1);
    sd.sd_ack = 1'b0;
    @(negedge clk_sys);
  endtask

  initial begin
    reset = 1'b1; cart_download = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
    img_size_nz = 1'b1; load_req = 1'b0; save_req = 1'b0; autosave_en = 1'b0;
    osd_status = 1'b0; bram_change = 1'b0; sd.sd_ack = 1'b0; sd.sd_buff_wr = 1'b0;
    step(3);
    chk("rst_busy", 32'(bk_busy), 32'd0);
    chk("rst_ena", 32'(bk_ena), 32'd0);
    chk("rst_rdwr", 32'(sd.sd_rd | sd.sd_wr), 32'd0);
    chk("rst_lba", sd.sd_lba, 32'd0);
    chk("rst_pend", 32'(sav_pending), 32'd0);
    reset = 1'b0;
    step(2);

    // bk_ena low: requests must be ignored
    load_req = 1'b1; step(2); load_req = 1'b0; save_req = 1'b1; step(2); save_req = 1'b0;
    step(1);
    chk("noena_busy", 32'(bk_busy), 32'd0);
    chk("noena_rdwr", 32'(sd.sd_rd | sd.sd_wr), 32'd0);

    // Download with writable image mounted enables backup, falling edge loads
    cart_download = 1'b1; img_mounted = 1'b1;
    step(1);
    chk("ena_set", 32'(bk_ena), 32'd1);
    img_mounted = 1'b0; cart_download = 1'b0;
    step(1);
    chk("load_busy", 32'(bk_busy), 32'd1);
    chk("load_loading", 32'(bk_loading), 32'd1);
    for (int i = 0; i < 3; i++) do_sector(i, 1'b1);
    // save edge mid-transfer is dropped; bram_change sets pending even while busy
    save_req = 1'b1; bram_change = 1'b1;
    step(1);
    chk("pend_set", 32'(sav_pending), 32'd1);
    chk("save_ignored_rd", 32'(sd.sd_rd), 32'd1);
    chk("save_ignored_wr", 32'(sd.sd_wr), 32'd0);
    bram_change = 1'b0;
    step(1);
    chk("pend_clr_busy", 32'(sav_pending), 32'd0);
    save_req = 1'b0;
    for (int i = 3; i < 128; i++) do_sector(i, 1'b1);
    chk("load_done_busy", 32'(bk_busy), 32'd0);
    chk("load_done_loading", 32'(bk_loading), 32'd0);
    chk("load_done_rdwr", 32'(sd.sd_rd | sd.sd_wr), 32'd0);
    step(3);
    chk("idle_stays", 32'(bk_busy), 32'd0);

    // Save: write requests only, bram_we held off
    save_req = 1'b1;
    step(1);
    chk("save_busy", 32'(bk_busy), 32'd1);
    chk("save_loading", 32'(bk_loading), 32'd0);
    save_req = 1'b0;
    for (int i = 0; i < 128; i++) do_sector(i, 1'b0);
    chk("save_done_busy", 32'(bk_busy), 32'd0);

    // Simultaneous load/save rise picks load; hold ack long, then reset mid-transfer
    load_req = 1'b1; save_req = 1'b1;
    step(1);
    chk("both_rd", 32'(sd.sd_rd), 32'd1);
    chk("both_wr", 32'(sd.sd_wr), 32'd0);
    chk("both_loading", 32'(bk_loading), 32'd1);
    for (int i = 0; i < 4; i++) do_sector(i, 1'b1);
    sd.sd_ack = 1'b1;
    step(30);
    chk("ackhold_busy", 32'(bk_busy), 32'd1);
    chk("ackhold_lba", sd.sd_lba, 32'd4);
    sd.sd_ack = 1'b0;
    step(1);
    chk("pre_rst_lba", sd.sd_lba, 32'd5);
    chk("pre_rst_rd", 32'(sd.sd_rd), 32'd1);
    reset = 1'b1;
    step(1);
    chk("abort_busy", 32'(bk_busy), 32'd0);
    chk("abort_rd", 32'(sd.sd_rd), 32'd0);
    chk("abort_lba", sd.sd_lba, 32'd0);
    chk("abort_loading", 32'(bk_loading), 32'd0);
    reset = 1'b0; load_req = 1'b0; save_req = 1'b0;
    step(2);

    // Autosave: re-enable without loading, mark pending, then open OSD
    img_size_nz = 1'b0; cart_download = 1'b1; img_mounted = 1'b1;
    step(1);
    img_mounted = 1'b0; cart_download = 1'b0;
    step(2);
    chk("ena_again", 32'(bk_ena), 32'd1);
    chk("no_load_size0", 32'(bk_busy), 32'd0);
    autosave_en = 1'b1; bram_change = 1'b1;
    step(1);
    bram_change = 1'b0;
    chk("auto_pend", 32'(sav_pending), 32'd1);
    osd_status = 1'b1;
    step(1);
`ifdef BK_AUTOSAVE_EN
    chk("auto_wr", 32'(sd.sd_wr), 32'd1);
    chk("auto_busy", 32'(bk_busy), 32'd1);
    step(1);
    chk("auto_pend_clr", 32'(sav_pending), 32'd0);
    for (int i = 0; i < 128; i++) do_sector(i, 1'b0);
    chk("auto_done", 32'(bk_busy), 32'd0);
`else
    step(2);
    chk("noauto_busy", 32'(bk_busy), 32'd0);
    chk("noauto_wr", 32'(sd.sd_wr), 32'd0);
    chk("noauto_pend", 32'(sav_pending), 32'd1);
`endif
    osd_status = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound in case the design stalls somewhere unexpected
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bk_sd_ctrl.md
BK_SD_CTRL -- requirements
Module: bk_sd_ctrl

Interface
REQ-001 SHALL provide parameter SECTORS, default 128, sectors per backup image; power of two, 2..128.
REQ-002 SHALL provide the following ports, one clock domain; clk_sys is the single clock and reset is synchronous, active-high.
- clk_sys  in  1  system clock
- reset  in  1  sync active-high; top-level/user reset only, never a reset derived from bk_loading
- cart_download  in  1  cartridge download active
- img_mounted  in  1  save image mount strobe
- img_readonly  in  1  mounted image is read-only
- img_size_nz  in  1  mounted image size nonzero
- load_req  in  1  manual load level (OSD)
- save_req  in  1  manual save level (OSD)
- autosave_en  in  1  autosave option
- osd_status  in  1  OSD open
- bram_change  in  1  core wrote backup RAM
- sd_ack  in  1  HPS sector handshake
- sd_buff_wr  in  1  HPS buffer write strobe
- sd_lba  out  32  sector address
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- bram_sector  out  7  sd_lba[6:0] for backup RAM address
- bram_we  out  1  backup RAM write enable
- bk_ena  out  1  backup image usable
- bk_loading  out  1  load in progress
- bk_busy  out  1  transfer in progress
- sav_pending  out  1  unsaved changes exist

Function
REQ-003 SHALL register load_req, save trigger, cart_download, sd_ack one cycle; edges compare current against registered value.
REQ-004 SHALL clear bk_ena on cart_download rising edge; set when cart_download & img_mounted & ~img_readonly; set wins in same cycle.
REQ-005 SHALL implement states IDLE and XFER; bk_busy=1 exactly in XFER.
REQ-006 IDLE start priority: (a) cart_download falling edge & img_size_nz & bk_ena -> load; (b) load_req rising & bk_ena -> load; (c) save trigger rising & bk_ena -> save; else remain IDLE.
REQ-007 On start SHALL set sd_lba=0, bk_loading=(load), sd_rd=load, sd_wr=~load, enter XFER; all registered, visible next cycle.
REQ-008 SHALL clear sd_rd and sd_wr in the cycle after sd_ack rising edge detected, in any state.
REQ-009 In XFER on sd_ack falling edge: if sd_lba[6:0]==SECTORS-1 -> bk_loading=0, IDLE; else sd_lba+1 and re-assert sd_rd=bk_loading, sd_wr=~bk_loading.
REQ-010 Request edges arriving in XFER SHALL be discarded, not queued.
REQ-011 sd_lba[31:7] SHALL stay 0; sd_lba never wraps beyond SECTORS-1.
REQ-012 bram_we SHALL be combinational sd_buff_wr & sd_ack & bk_loading.
REQ-013 sav_pending SHALL set when bram_change & ~osd_status; else clear when bk_busy; set wins.
REQ-014 sd_rd and sd_wr SHALL never both be 1.
REQ-015 sd_ack held high indefinitely SHALL hold XFER; no timeout.

Reset
REQ-016 reset SHALL force IDLE, sd_lba=0, sd_rd=0, sd_wr=0, bk_loading=0, bk_ena=0, sav_pending=0, edge registers=0; mid-transfer reset aborts without completing the sector.
REQ-017 First cycle after reset SHALL NOT produce edges from inputs already high.

Configuration
REQ-018 Macro BK_AUTOSAVE_EN defined: save trigger = save_req | (sav_pending & osd_status & autosave_en).
REQ-019 BK_AUTOSAVE_EN undefined: save trigger = save_req; autosave_en ignored; sav_pending still tracked.

Verification
REQ-020 Download 1->0 with bk_ena=1, img_size_nz=1, SECTORS=128, ack pulse per sector -> 128 sd_rd requests, lba 0..127, bk_loading falls after ack fall of lba 127.
REQ-021 save_req rising, bk_ena=1 -> sd_wr only, lba 0..127, bram_we stays 0 despite sd_buff_wr pulses.
REQ-022 bk_ena=0, load_req/save_req toggled -> no sd_rd/sd_wr, stays IDLE.
REQ-023 reset at lba=5 with sd_rd=1 -> next cycle IDLE, sd_rd=0, sd_lba=0, bk_loading=0.
REQ-024 BK_AUTOSAVE_EN, autosave_en=1, bram_change with osd_status=0 then osd_status 0->1 -> save starts, sav_pending clears; macro undefined -> no save.
REQ-025 load_req and save_req rise same cycle -> load chosen; save_req rise during XFER -> ignored.
